hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//   Parametrised scoreboard hazard unit for the multi-cycle/cache core. It
//   generalises the single load-use check to any number of in-flight writers.
//   Each writer has either a fixed latency (ALU, MUL, DIV) or a variable one
//   (load through the cache, retired by ld_done). The block sits beside ID
//   and holds the instruction in ID until none of its sources or its
//   destination is still pending.
// PARAMETERS
//   NUM_REGS  32  architectural registers; x0 is never tracked
//   REG_W     5   register index width, = clog2(NUM_REGS)
//   MAX_LAT   8   largest fixed latency accepted on id_lat
//   LAT_W     4   countdown width, = clog2(MAX_LAT+1)
// PORTS
//   clk          in   1         core clock
//   rst_n        in   1         asynchronous active-low reset
//   id_valid     in   1         ID holds a valid instruction
//   id_rs1       in   REG_W     source 1 index
//   id_rs2       in   REG_W     source 2 index
//   id_rs1_used  in   1         source 1 is actually read
//   id_rs2_used  in   1         source 2 is actually read
//   id_wr        in   1         instruction writes id_rd
//   id_rd        in   REG_W     destination index
//   id_var       in   1         variable-latency writer (load); id_lat ignored
//   id_lat       in   LAT_W     fixed latency, 1..MAX_LAT cycles
//   ld_done      in   1         a load result is available this cycle
//   ld_done_rd   in   REG_W     destination of that load
//   freeze       in   1         pipeline frozen (cache miss); countdowns hold
//   flush        in   1         ID instruction squashed; no issue this cycle
//   stall        out  1         hold PC/IF/ID and inject a bubble into EX
//   busy_vec     out  NUM_REGS  per-register pending flags (debug); bit0 = 0
// BEHAVIOUR
//   Per-entry state, r = 1..NUM_REGS-1:
//     busy bit, var bit, cnt[LAT_W]. Reset (async): all zero, so stall = 0
//     and busy_vec = 0.
//   Hazard (combinational from registered state only):
//     raw1 = id_rs1_used & rs1 != 0 & busy[rs1]; same form for raw2
//     waw  = id_wr & rd != 0 & busy[rd]
//     stall = id_valid & (raw1 | raw2 | waw)
//     stall does not depend on freeze or flush.
//   Issue:
//     issue = id_valid & ~stall & ~flush & ~freeze & id_wr & id_rd != 0
//     On issue, at the next edge entry[rd] becomes:
//       busy = 1, var = id_var, cnt = id_var ? 0 : id_lat
//   Countdown (fixed-latency entries):
//     Busy & ~var entries with ~freeze decrement cnt each cycle.
//     On the 1 -> 0 step the entry clears busy at the same edge.
//     Latency L therefore makes rd busy for exactly L cycles after the
//     issue edge.
//   Load retire (variable-latency entries):
//     ld_done clears entry[ld_done_rd] if it is busy & var.
//     It is honoured even while freeze = 1.
//     It is ignored for x0, for non-busy entries and for ~var entries.
//   Simultaneous events:
//     - issue and retire/countdown-clear on the same rd: issue wins and the
//       new entry is written.
//     - Issue with id_lat = 0 and ~id_var is illegal; the entry is treated as
//       latency 1. An id_lat above MAX_LAT saturates to MAX_LAT.
//     - A register that retires at edge N unblocks the stall in cycle N+1.
//       There is no same-cycle bypass of the clear.
//   flush: existing entries are kept; only this cycle's issue is suppressed.
//   Reset mid-operation: all entries drop at once, and in-flight loads are
//   forgotten. A later ld_done for them is ignored by the rules above.
// STRUCTURE
//   Shared package hazard_pkg: REG_W, LAT_W, MAX_LAT, and the entry struct
//   {busy, var, cnt}.
//   Sub-module hazard_sb_entry is instantiated with a generate loop for
//   r = 1..NUM_REGS-1. Its inputs are set_en, set_var, set_lat, clr_ld and
//   freeze; its outputs are busy and var. The top level holds only the
//   index decoders and the hazard OR tree.
// TESTING
//   1. Reset, then idle: stall = 0 and busy_vec = 0.
//      Pull rst_n low mid-countdown: busy_vec = 0 asynchronously.
//   2. Issue rd=5 with lat=3, then hold ID with rs1=5 used:
//      stall = 1 for 3 cycles, then 0 on the 4th.
//   3. Issue a load rd=7 with var=1. ID reads rs2=7.
//      stall stays 1 until ld_done/ld_done_rd=7 arrives, then 0 the next cycle.
//   4. Issue rd=9 with lat=2, then assert freeze for 4 cycles:
//      busy[9] holds through the freeze and clears 2 cycles after it ends.
//      A ld_done during the freeze still clears a var entry.
//   5. WAW and x0: with rd=3 busy, an ID write to rd=3 gives stall = 1.
//      id_rd=0 and rs1=0 never stall, and busy_vec[0] stays 0.
//   6. flush with a non-stalled write to rd=4: busy[4] stays 0.
//      Same cycle, ld_done_rd=4 for a stale load is ignored.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared widths, entry record and latency clamp for the hazard scoreboard.
package hazard_pkg;
    localparam int NUM_REGS = 32;
    localparam int REG_W    = 5;
    localparam int MAX_LAT  = 8;
    localparam int LAT_W    = 4;

    typedef struct packed {
        logic             busy;
        logic             is_var;
        logic [LAT_W-1:0] cnt;
    } sb_entry_t;

    // Zero is illegal and runs as one cycle; oversize requests saturate.
    function automatic logic [LAT_W-1:0] sat_lat(input logic [LAT_W-1:0] lat);
        if (lat == '0)
            return LAT_W'(1);
        else if (lat > LAT_W'(MAX_LAT))
            return LAT_W'(MAX_LAT);
        else
            return lat;
    endfunction
endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard entry: pending flag, load flag and fixed-latency countdown.
module hazard_sb_entry
    import hazard_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_en,
    input  logic             set_var,
    input  logic [LAT_W-1:0] set_lat,
    input  logic             clr_ld,
    input  logic             freeze,
    output logic             busy,
    output logic             is_var
);
    sb_entry_t ent_q, ent_d;

    always_comb begin
        ent_d = ent_q;
        if (ent_q.busy && !ent_q.is_var && !freeze) begin
            if (ent_q.cnt <= LAT_W'(1))
                ent_d = '0;
            else
                ent_d.cnt = ent_q.cnt - LAT_W'(1);
        end
        // Load retire is honoured regardless of freeze.
        if (clr_ld && ent_q.busy && ent_q.is_var)
            ent_d = '0;
        // A new issue overrides any clear landing on the same edge.
        if (set_en) begin
            ent_d.busy   = 1'b1;
            ent_d.is_var = set_var;
            ent_d.cnt    = set_var ? '0 : sat_lat(set_lat);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ent_q <= '0;
        else
            ent_q <= ent_d;
    end

    assign busy   = ent_q.busy;
    assign is_var = ent_q.is_var;
endmodule

// File: rtl/hazard_scoreboard.sv
// Multi-writer hazard unit beside ID: index decoders, per-register entries and
// the RAW/WAW OR tree that holds the ID instruction.
module hazard_scoreboard
    import hazard_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                id_valid,
    input  logic [REG_W-1:0]    id_rs1,
    input  logic [REG_W-1:0]    id_rs2,
    input  logic                id_rs1_used,
    input  logic                id_rs2_used,
    input  logic                id_wr,
    input  logic [REG_W-1:0]    id_rd,
    input  logic                id_var,
    input  logic [LAT_W-1:0]    id_lat,
    input  logic                ld_done,
    input  logic [REG_W-1:0]    ld_done_rd,
    input  logic                freeze,
    input  logic                flush,
    output logic                stall,
    output logic [NUM_REGS-1:0] busy_vec
);
    logic [NUM_REGS-1:0] busy_w, var_w;
    logic raw1, raw2, waw, issue;

    assign busy_w[0] = 1'b0;
    assign var_w[0]  = 1'b0;

    // Hazards look only at registered state, so a clear is seen a cycle later.
    assign raw1  = id_rs1_used && (id_rs1 != '0) && busy_w[id_rs1];
    assign raw2  = id_rs2_used && (id_rs2 != '0) && busy_w[id_rs2];
    assign waw   = id_wr && (id_rd != '0) && busy_w[id_rd];
    assign stall = id_valid && (raw1 || raw2 || waw);
    assign issue = id_valid && !stall && !flush && !freeze && id_wr && (id_rd != '0);

    genvar r;
    generate
        for (r = 1; r < NUM_REGS; r++) begin : g_ent
            hazard_sb_entry u_ent (
                .clk     (clk),
                .rst_n   (rst_n),
                .set_en  (issue && (id_rd == REG_W'(r))),
                .set_var (id_var),
                .set_lat (id_lat),
                .clr_ld  (ld_done && (ld_done_rd == REG_W'(r)) && var_w[r]),
                .freeze  (freeze),
                .busy    (busy_w[r]),
                .is_var  (var_w[r])
            );
        end
    endgenerate

    assign busy_vec = busy_w;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed, table-driven bench for hazard_scoreboard with hand-computed expectations.
module tb_hazard_scoreboard;
    import hazard_pkg::*;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                id_valid, id_rs1_used, id_rs2_used, id_wr, id_var;
    logic [REG_W-1:0]    id_rs1, id_rs2, id_rd, ld_done_rd;
    logic [LAT_W-1:0]    id_lat;
    logic                ld_done, freeze, flush;
    logic                stall;
    logic [NUM_REGS-1:0] busy_vec;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        valid, rs1u, rs2u, wr, isvar, ldd, frz, fl;
        logic [4:0]  rs1, rs2, rd, ldrd;
        logic [3:0]  lat;
        logic        est;
        logic [31:0] ebusy;
    } vec_t;

    vec_t vecs[$];

    hazard_scoreboard dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_wr(id_wr), .id_rd(id_rd),
        .id_var(id_var), .id_lat(id_lat), .ld_done(ld_done), .ld_done_rd(ld_done_rd),
        .freeze(freeze), .flush(flush), .stall(stall), .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic valid, input int rs1, input logic rs1u,
                                input int rs2, input logic rs2u, input logic wr, input int rd,
                                input logic isvar, input int lat, input logic ldd, input int ldrd,
                                input logic frz, input logic fl, input logic est, input logic [31:0] ebusy);
        vec_t v;
        v.valid = valid; v.rs1 = 5'(rs1); v.rs1u = rs1u; v.rs2 = 5'(rs2); v.rs2u = rs2u;
        v.wr = wr; v.rd = 5'(rd); v.isvar = isvar; v.lat = 4'(lat); v.ldd = ldd;
        v.ldrd = 5'(ldrd); v.frz = frz; v.fl = fl; v.est = est; v.ebusy = ebusy;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        id_valid = v.valid; id_rs1 = v.rs1; id_rs1_used = v.rs1u; id_rs2 = v.rs2;
        id_rs2_used = v.rs2u; id_wr = v.wr; id_rd = v.rd; id_var = v.isvar; id_lat = v.lat;
        ld_done = v.ldd; ld_done_rd = v.ldrd; freeze = v.frz; flush = v.fl;
    endtask

    task automatic chk(input string name, input logic est, input logic [31:0] ebusy);
        checks++;
        if (stall !== est || busy_vec !== ebusy) begin
            errors++;
            $display("FAIL %s: stall=%0b busy_vec=%h, required stall=%0b busy_vec=%h",
                     name, stall, busy_vec, est, ebusy);
        end
    endtask

    initial begin
        int stall_cycles;
        rst_n = 1'b0;
        drive(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", 1'b0, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;

        // lat=3 RAW on rs1
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,32'h0));
        vecs.push_back(mk(1,0,0,0,0,1,5,0,3,0,0,0,0,0,32'h0));
        repeat (3) vecs.push_back(mk(1,5,1,0,0,0,0,0,0,0,0,0,0,1,32'h20));
        vecs.push_back(mk(1,5,1,0,0,0,0,0,0,0,0,0,0,0,32'h0));
        // load rd=7, RAW on rs2 until ld_done
        vecs.push_back(mk(1,0,0,0,0,1,7,1,0,0,0,0,0,0,32'h0));
        repeat (2) vecs.push_back(mk(1,0,0,7,1,0,0,0,0,0,0,0,0,1,32'h80));
        vecs.push_back(mk(1,0,0,7,1,0,0,0,0,1,7,0,0,1,32'h80));
        vecs.push_back(mk(1,0,0,7,1,0,0,0,0,0,0,0,0,0,32'h0));
        // WAW on rd=3, x0 never stalls
        vecs.push_back(mk(1,0,0,0,0,1,3,0,2,0,0,0,0,0,32'h0));
        vecs.push_back(mk(1,0,0,0,0,1,3,0,1,0,0,0,0,1,32'h8));
        vecs.push_back(mk(1,0,1,0,1,1,0,0,1,0,0,0,0,0,32'h8));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,32'h0));
        // flush suppresses issue; stale ld_done ignored
        vecs.push_back(mk(1,0,0,0,0,1,4,0,3,1,4,0,1,0,32'h0));
        vecs.push_back(mk(1,4,1,0,0,0,0,0,0,0,0,0,0,0,32'h0));
        // lat=0 behaves as 1
        vecs.push_back(mk(1,0,0,0,0,1,6,0,0,0,0,0,0,0,32'h0));
        vecs.push_back(mk(1,6,1,0,0,0,0,0,0,0,0,0,0,1,32'h40));
        vecs.push_back(mk(1,6,1,0,0,0,0,0,0,0,0,0,0,0,32'h0));
        // ld_done on a fixed-latency entry is ignored
        vecs.push_back(mk(1,0,0,0,0,1,11,0,2,0,0,0,0,0,32'h0));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,1,11,0,0,0,32'h800));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,32'h800));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,32'h0));
        // freeze holds countdown; ld_done during freeze clears load
        vecs.push_back(mk(1,0,0,0,0,1,12,1,0,0,0,0,0,0,32'h0));
        vecs.push_back(mk(1,0,0,0,0,1,9,0,2,0,0,0,0,0,32'h1000));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,1,0,0,32'h1200));
        vecs.push_back(mk(1,9,1,0,0,0,0,0,0,0,0,1,0,1,32'h1200));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,1,12,1,0,0,32'h1200));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,1,0,0,32'h200));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,32'h200));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,32'h200));
        vecs.push_back(mk(0,0,0,0,0,0,0,0,0,0,0,0,0,0,32'h0));

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(negedge clk);
            chk($sformatf("vec%0d", i), vecs[i].est, vecs[i].ebusy);
            @(posedge clk); #1;
        end

        // Oversize latency saturates to MAX_LAT cycles of busy
        drive(mk(1,0,0,0,0,1,10,0,15,0,0,0,0,0,0));
        @(posedge clk); #1;
        drive(mk(1,10,1,0,0,0,0,0,0,0,0,0,0,0,0));
        stall_cycles = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (stall) stall_cycles++;
            @(posedge clk); #1;
        end
        checks++;
        if (stall_cycles != MAX_LAT) begin
            errors++;
            $display("FAIL lat_saturate: stalled %0d cycles, required %0d", stall_cycles, MAX_LAT);
        end

        // Asynchronous reset mid-countdown
        drive(mk(1,0,0,0,0,1,5,0,5,0,0,0,0,0,0));
        @(posedge clk); #1;
        drive(mk(1,5,1,0,0,0,0,0,0,0,0,0,0,0,0));
        @(negedge clk);
        chk("pre_reset", 1'b1, 32'h20);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", 1'b0, 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        drive(mk(1,0,0,0,0,0,0,0,0,1,7,0,0,0,0));
        @(negedge clk);
        chk("post_reset", 1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
